// File: rtl/bunch_sample_capture_pkg.sv
// Shared types and width helpers for the bunch sample capture block.
package bunch_sample_capture_pkg;

    // Width of the bunch index and bunch count ports
    localparam int IDX_W = 2;

    // FSM state encoding kept as plain constants for legacy tools
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ARMED = 2'd1;
    localparam state_t ST_ACCUM = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Accumulator width that cannot wrap: one sign bit plus log2 growth
    function automatic int sum_width(input int data_w, input int max_samples);
        return data_w + $clog2(max_samples) + 1;
    endfunction

    // Sample counter width able to hold the value max_samples itself
    function automatic int nsamp_width(input int max_samples);
        return $clog2(max_samples) + 1;
    endfunction

endpackage

// File: rtl/bunch_accumulator.sv
// Saturating-count signed accumulator: load the first sample, add the
// following ones until MAX_SAMPLES are held, then drop and flag overflow.
module bunch_accumulator
    import bunch_sample_capture_pkg::*;
#(
    parameter int DATA_W      = 13,
    parameter int MAX_SAMPLES = 16,
    parameter int SUM_W       = sum_width(DATA_W, MAX_SAMPLES),
    parameter int NSAMP_W     = nsamp_width(MAX_SAMPLES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               add,
    input  logic               clr_ovf,
    input  logic [DATA_W-1:0]  sample,
    output logic [SUM_W-1:0]   sum,
    output logic [NSAMP_W-1:0] nsamp,
    output logic               ovf
);

    localparam logic [NSAMP_W-1:0] N_MAX = NSAMP_W'(MAX_SAMPLES);

    logic [SUM_W-1:0] sample_ext;

    // Sign-extend the raw two's-complement sample to accumulator width
    assign sample_ext = {{(SUM_W-DATA_W){sample[DATA_W-1]}}, sample};

    // Accumulate while below the sample limit; beyond it samples are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            nsamp <= '0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                sum   <= sample_ext;
                nsamp <= NSAMP_W'(1);
            end else if (add) begin
                if (nsamp < N_MAX) begin
                    sum   <= sum + sample_ext;
                    nsamp <= nsamp + 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end
            if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bunch_sample_capture.sv
// Bunch strobe receiver: per store window, sums the ADC samples inside each
// bunch window and emits one result per bunch, plus malformed-traffic flags.
module bunch_sample_capture
    import bunch_sample_capture_pkg::*;
#(
    parameter int DATA_W      = 13,
    parameter int MAX_BUNCHES = 3,
    parameter int MAX_SAMPLES = 16,
    parameter int SUM_W       = sum_width(DATA_W, MAX_SAMPLES),
    localparam int NSAMP_W    = nsamp_width(MAX_SAMPLES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               store_strb,
    input  logic               bunch_strb,
    input  logic [DATA_W-1:0]  adc_data,
    output logic               result_valid,
    output logic [SUM_W-1:0]   result_sum,
    output logic [NSAMP_W-1:0] result_nsamp,
    output logic [IDX_W-1:0]   result_idx,
    output logic               result_last,
    output logic               frame_done,
    output logic [IDX_W-1:0]   bunch_count,
    output logic               overflow_err,
    output logic               extra_bunch_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BUNCHES - 1);

    // Input stage and edge history
    logic              store_q, store_qq;
    logic              bunch_q, bunch_qq;
    logic [DATA_W-1:0] adc_q;
    logic              store_rise, store_fall, bunch_rise;

    // FSM and control strobes
    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg;
    logic             acc_load, acc_add, acc_clr_ovf;
    logic             capture, frame_start, frame_end, extra_set;

    // Completed bunch waiting one stage before it reaches the outputs
    logic               pend_valid_reg;
    logic [SUM_W-1:0]   pend_sum_reg;
    logic [NSAMP_W-1:0] pend_nsamp_reg;
    logic [IDX_W-1:0]   pend_idx_reg;
    logic               pend_last_reg;

    logic [SUM_W-1:0]   acc_sum;
    logic [NSAMP_W-1:0] acc_nsamp;

    // Register all inputs once so strobes and data stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q  <= 1'b0;
            store_qq <= 1'b0;
            bunch_q  <= 1'b0;
            bunch_qq <= 1'b0;
            adc_q    <= '0;
        end else begin
            store_q  <= store_strb;
            store_qq <= store_q;
            bunch_q  <= bunch_strb;
            bunch_qq <= bunch_q;
            adc_q    <= adc_data;
        end
    end

    assign store_rise = store_q & ~store_qq;
    assign store_fall = ~store_q & store_qq;
    assign bunch_rise = bunch_q & ~bunch_qq;

    // Next-state logic; a store fall preempts everything else in a frame
    always_comb begin
        state_next  = state_reg;
        acc_load    = 1'b0;
        acc_add     = 1'b0;
        acc_clr_ovf = 1'b0;
        capture     = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        extra_set   = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (store_rise) begin
                state_next  = ST_ARMED;
                frame_start = 1'b1;
                acc_clr_ovf = 1'b1;
            end
        end else if (store_fall) begin
            state_next = ST_IDLE;
            frame_end  = 1'b1;
        end else begin
            case (state_reg)
                ST_ARMED: begin
                    if (bunch_rise) begin
                        acc_load   = 1'b1;
                        state_next = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (bunch_q) begin
                        acc_add = 1'b1;
                    end else begin
                        capture    = 1'b1;
                        state_next = (idx_reg == LAST_IDX) ? ST_DONE : ST_ARMED;
                    end
                end
                ST_DONE: begin
                    if (bunch_rise) begin
                        extra_set = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Per-frame bookkeeping: bunch index, completed count, extra-bunch flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg         <= '0;
            bunch_count     <= '0;
            extra_bunch_err <= 1'b0;
        end else begin
            if (frame_start) begin
                idx_reg         <= '0;
                bunch_count     <= '0;
                extra_bunch_err <= 1'b0;
            end else if (capture) begin
                idx_reg     <= idx_reg + 1'b1;
                bunch_count <= bunch_count + 1'b1;
            end
            if (extra_set) begin
                extra_bunch_err <= 1'b1;
            end
        end
    end

    // Latch a finished bunch, then present it on the outputs one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_reg <= 1'b0;
            pend_sum_reg   <= '0;
            pend_nsamp_reg <= '0;
            pend_idx_reg   <= '0;
            pend_last_reg  <= 1'b0;
            result_valid   <= 1'b0;
            result_sum     <= '0;
            result_nsamp   <= '0;
            result_idx     <= '0;
            result_last    <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            pend_valid_reg <= capture;
            if (capture) begin
                pend_sum_reg   <= acc_sum;
                pend_nsamp_reg <= acc_nsamp;
                pend_idx_reg   <= idx_reg;
                pend_last_reg  <= (idx_reg == LAST_IDX);
            end
            result_valid <= pend_valid_reg;
            if (pend_valid_reg) begin
                result_sum   <= pend_sum_reg;
                result_nsamp <= pend_nsamp_reg;
                result_idx   <= pend_idx_reg;
                result_last  <= pend_last_reg;
            end
            frame_done <= frame_end;
        end
    end

    bunch_accumulator #(
        .DATA_W      (DATA_W),
        .MAX_SAMPLES (MAX_SAMPLES),
        .SUM_W       (SUM_W),
        .NSAMP_W     (NSAMP_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (acc_load),
        .add     (acc_add),
        .clr_ovf (acc_clr_ovf),
        .sample  (adc_q),
        .sum     (acc_sum),
        .nsamp   (acc_nsamp),
        .ovf     (overflow_err)
    );

endmodule

// File: tb/tb_bunch_sample_capture.sv
// Self-checking bench: stimulus streams are built up front, a window-level
// reference model derives the expected result / frame events per clock edge,
// then the stream is driven and every cycle is compared.
module tb_bunch_sample_capture;

    localparam int DATA_W = 13;
    localparam int MAXB   = 3;
    localparam int MAXS   = 16;
    localparam int SUM_W  = 18;
    localparam int MAXE   = 8192;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              store_strb = 1'b0;
    logic              bunch_strb = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              result_valid;
    logic [SUM_W-1:0]  result_sum;
    logic [4:0]        result_nsamp;
    logic [1:0]        result_idx;
    logic              result_last;
    logic              frame_done;
    logic [1:0]        bunch_count;
    logic              overflow_err;
    logic              extra_bunch_err;

    always #5 clk = ~clk;

    bunch_sample_capture #(
        .DATA_W      (DATA_W),
        .MAX_BUNCHES (MAXB),
        .MAX_SAMPLES (MAXS),
        .SUM_W       (SUM_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .store_strb      (store_strb),
        .bunch_strb      (bunch_strb),
        .adc_data        (adc_data),
        .result_valid    (result_valid),
        .result_sum      (result_sum),
        .result_nsamp    (result_nsamp),
        .result_idx      (result_idx),
        .result_last     (result_last),
        .frame_done      (frame_done),
        .bunch_count     (bunch_count),
        .overflow_err    (overflow_err),
        .extra_bunch_err (extra_bunch_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Stimulus stream, one entry per clock edge
    bit st_q[$];
    bit bs_q[$];
    int ad_q[$];

    // Expected events, indexed by the edge after which they are visible
    bit     exp_v[MAXE];
    longint exp_sum[MAXE];
    int     exp_n[MAXE];
    int     exp_idx[MAXE];
    bit     exp_last[MAXE];
    bit     exp_fd[MAXE];
    int     exp_cnt[MAXE];
    bit     exp_ovf[MAXE];
    bit     exp_xb[MAXE];

    function automatic int rnd_adc();
        return int'($urandom_range(0, 8191)) - 4096;
    endfunction

    task automatic push(input bit s, input bit b, input int a);
        st_q.push_back(s);
        bs_q.push_back(b);
        ad_q.push_back(a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, rnd_adc());
    endtask

    // Reference model: walk frames and bunch windows of the stream.
    // A window covering edges k..m-1 inside a frame ending at edge f
    // completes only if m < f; its result is visible after edge m+2 and
    // frame_done after edge f+1.
    task automatic build_model();
        int n, e, s, f, j, k, m, done_cnt, seen, take;
        bit ovf, xb;
        longint sum;
        n = st_q.size();
        for (int i = 0; i < MAXE; i++) begin
            exp_v[i] = 0; exp_sum[i] = 0; exp_n[i] = 0; exp_idx[i] = 0;
            exp_last[i] = 0; exp_fd[i] = 0; exp_cnt[i] = 0;
            exp_ovf[i] = 0; exp_xb[i] = 0;
        end
        e = 0;
        while (e < n) begin
            if (st_q[e] && (e == 0 || !st_q[e-1])) begin
                s = e;
                f = e;
                while (f < n && st_q[f]) f++;
                done_cnt = 0;
                ovf = 0;
                xb = 0;
                j = s + 1;
                while (j < f) begin
                    if (bs_q[j] && !bs_q[j-1]) begin
                        k = j;
                        m = j;
                        while (m < n && bs_q[m]) m++;
                        if (done_cnt < MAXB) begin
                            seen = ((m < f) ? m : f) - k;
                            if (seen > MAXS) ovf = 1;
                            if (m < f) begin
                                take = (m - k > MAXS) ? MAXS : (m - k);
                                sum = 0;
                                for (int t = 0; t < take; t++) sum += ad_q[k+t];
                                exp_v[m+2]    = 1;
                                exp_sum[m+2]  = sum;
                                exp_n[m+2]    = take;
                                exp_idx[m+2]  = done_cnt;
                                exp_last[m+2] = (done_cnt == MAXB - 1);
                                done_cnt++;
                            end
                        end else begin
                            xb = 1;
                        end
                        j = m;
                    end else begin
                        j++;
                    end
                end
                exp_fd[f+1]  = 1;
                exp_cnt[f+1] = done_cnt;
                exp_ovf[f+1] = ovf;
                exp_xb[f+1]  = xb;
                e = f;
            end else begin
                e++;
            end
        end
    endtask

    // Drive the stream (starting at a negedge) and compare every cycle
    task automatic run_stream(input string name);
        int n;
        n = st_q.size();
        if (n > MAXE - 4) begin
            $display("FAIL stream_len: got %0d, expected below %0d", n, MAXE - 4);
            errors++;
            $fatal(1, "stream too long");
        end
        build_model();
        for (int e = 0; e < n; e++) begin
            store_strb = st_q[e];
            bunch_strb = bs_q[e];
            adc_data   = DATA_W'(ad_q[e]);
            @(posedge clk);
            @(negedge clk);
            chk("result_valid", longint'(result_valid), longint'(exp_v[e]));
            if (exp_v[e]) begin
                $display("[%s] result idx=%0d sum=%0d nsamp=%0d last=%0b",
                         name, result_idx, $signed(result_sum), result_nsamp, result_last);
                chk("result_sum", longint'($signed(result_sum)), exp_sum[e]);
                chk("result_nsamp", longint'(result_nsamp), longint'(exp_n[e]));
                chk("result_idx", longint'(result_idx), longint'(exp_idx[e]));
                chk("result_last", longint'(result_last), longint'(exp_last[e]));
            end
            chk("frame_done", longint'(frame_done), longint'(exp_fd[e]));
            if (exp_fd[e]) begin
                $display("[%s] frame_done count=%0d ovf=%0b extra=%0b",
                         name, bunch_count, overflow_err, extra_bunch_err);
                chk("bunch_count", longint'(bunch_count), longint'(exp_cnt[e]));
                chk("overflow_err", longint'(overflow_err), longint'(exp_ovf[e]));
                chk("extra_bunch_err", longint'(extra_bunch_err), longint'(exp_xb[e]));
            end
        end
        st_q.delete();
        bs_q.delete();
        ad_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, longint'(result_valid), 0);
        chk({tag, "_sum"}, longint'(result_sum), 0);
        chk({tag, "_nsamp"}, longint'(result_nsamp), 0);
        chk({tag, "_idx"}, longint'(result_idx), 0);
        chk({tag, "_last"}, longint'(result_last), 0);
        chk({tag, "_frame_done"}, longint'(frame_done), 0);
        chk({tag, "_count"}, longint'(bunch_count), 0);
        chk({tag, "_ovf"}, longint'(overflow_err), 0);
        chk({tag, "_extra"}, longint'(extra_bunch_err), 0);
    endtask

    // Scenarios from the test plan, plus back-to-back and 1-cycle windows
    task automatic build_directed();
        int w4[4];
        bit b;
        w4[0] = -5; w4[1] = 7; w4[2] = -3; w4[3] = 1;
        idle(3);
        for (int i = 0; i < 300; i++) begin
            b = (i == 10 || i == 110 || i == 210);
            push(1'b1, b, b ? 100 * (i / 100 + 1) : rnd_adc());
        end
        idle(3);
        for (int i = 0; i < 30; i++) begin
            b = (i >= 5 && i < 9);
            push(1'b1, b, b ? w4[i-5] : rnd_adc());
        end
        idle(3);
        for (int i = 0; i < 40; i++) begin
            b = (i >= 3 && i < 23);
            push(1'b1, b, b ? -4096 : rnd_adc());
        end
        idle(3);
        for (int i = 0; i < 40; i++) begin
            b = (i >= 3 && i < 6) || (i >= 7 && i < 9) || (i == 12) || (i >= 15 && i < 20);
            push(1'b1, b, rnd_adc());
        end
        idle(3);
        // second window falls on the same edge as the store window
        for (int i = 0; i < 30; i++) begin
            b = (i >= 3 && i < 8) || (i >= 12);
            push(1'b1, b, rnd_adc());
        end
        idle(3);
        // bunch still high after the store window ends
        for (int i = 0; i < 25; i++) begin
            b = (i >= 3 && i < 5) || (i >= 10);
            push(i < 20, b, rnd_adc());
        end
        idle(3);
        for (int i = 0; i < 20; i++) begin
            b = (i >= 4 && i < 6);
            push(1'b1, b, rnd_adc());
        end
        idle(4);
    endtask

    task automatic build_random(input int frames);
        bit bb[128];
        int len, pos, wl, lim;
        for (int fr = 0; fr < frames; fr++) begin
            idle(int'($urandom_range(2, 5)));
            len = int'($urandom_range(20, 120));
            for (int i = 0; i < 128; i++) bb[i] = 0;
            pos = int'($urandom_range(1, 6));
            while (pos < len) begin
                wl = int'($urandom_range(1, 22));
                lim = (pos + wl < len) ? pos + wl : len;
                for (int t = pos; t < lim; t++) bb[t] = 1;
                pos = pos + wl + int'($urandom_range(1, 6));
            end
            for (int i = 0; i < len; i++) push(1'b1, bb[i], rnd_adc());
        end
        idle(4);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        build_directed();
        run_stream("directed");

        build_random(20);
        run_stream("random");

        // Frame with an overflowing window, so outputs are non-zero afterwards
        idle(2);
        for (int i = 0; i < 40; i++) push(1'b1, (i >= 3 && i < 23), 77);
        idle(4);
        run_stream("pre_reset");

        // New frame, long window, reset asserted in the middle of it
        store_strb = 1'b1;
        bunch_strb = 1'b0;
        repeat (3) @(negedge clk);
        bunch_strb = 1'b1;
        adc_data   = DATA_W'(5);
        repeat (19) @(negedge clk);
        chk("pre_reset_ovf", longint'(overflow_err), 1);
        chk("pre_reset_sum", longint'($signed(result_sum)), 16 * 77);
        #2;
        rst_n      = 1'b0;
        store_strb = 1'b0;
        bunch_strb = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        idle(3);
        for (int i = 0; i < 30; i++) push(1'b1, (i >= 4 && i < 7) || (i >= 10 && i < 14), rnd_adc());
        idle(4);
        run_stream("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
